// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execute-stage ALU with an iterative shift-add multiplier
// ALU_FAST_MUL_EN: when defined, mul is single-cycle via '*' and no MUL state is built.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b0110;
  localparam logic [3:0] OP_SRAI = 4'b0111;
  localparam logic [3:0] OP_MEM  = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1001;

  logic [WIDTH-1:0] alu_res;
  logic [SW-1:0]    shamt;

  assign shamt = data2_i[SW-1:0];

  // Single-cycle result for every code; mul only meaningful in the fast build
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:  alu_res = data1_i & data2_i;
      OP_XOR:  alu_res = data1_i ^ data2_i;
      OP_SLL:  alu_res = data1_i << shamt;
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
`ifdef ALU_FAST_MUL_EN
      OP_MUL:  alu_res = data1_i * data2_i;
`endif
      OP_ADDI: alu_res = data1_i + data2_i;
      OP_SRAI: alu_res = $signed(data1_i) >>> shamt;
      OP_MEM:  alu_res = data1_i + data2_i;
      OP_BEQ:  alu_res = data1_i - data2_i;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_FAST_MUL_EN

  assign busy_o = 1'b0;

  // Every op, mul included, registers its result on the accepting edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      zero_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= start_i;
      if (start_i) begin
        data_o <= alu_res;
        zero_o <= (alu_res == '0);
      end
    end
  end

`else

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
  logic [CW-1:0]    count;
  logic             load_mul, wr_single, mul_done;

  // Next state and per-cycle control; acc_step folds in this edge's partial product
  always_comb begin
    state_n   = state;
    load_mul  = 1'b0;
    wr_single = 1'b0;
    mul_done  = 1'b0;
    acc_step  = acc + (mplier[0] ? mcand : '0);
    case (state)
      IDLE: begin
        if (start_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            load_mul = 1'b1;
            state_n  = MUL;
          end else begin
            wr_single = 1'b1;
          end
        end
      end
      MUL: begin
        if (count == CW'(1)) begin
          mul_done = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // Result registers and shift-add datapath; busy follows the next state so it stays registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      zero_o  <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      valid_o <= wr_single | mul_done;
      busy_o  <= (state_n == MUL);
      if (wr_single) begin
        data_o <= alu_res;
        zero_o <= (alu_res == '0);
      end
      if (mul_done) begin
        data_o <= acc_step;
        zero_o <= (acc_step == '0);
      end
      if (load_mul) begin
        mcand  <= data1_i;
        mplier <= data2_i;
        acc    <= '0;
        count  <= CW'(WIDTH);
      end else if (state == MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - CW'(1);
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle
module tb_alu_multicycle;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [31:0] data_o;
  logic        zero_o;
  logic        valid_o;
  logic        busy_o;

  int tests;
  int fails;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .data_o    (data_o),
    .zero_o    (zero_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".data"},  data_o,        32'h0);
    chk({tag, ".zero"},  32'(zero_o),   32'h0);
    chk({tag, ".valid"}, 32'(valid_o),  32'h0);
    chk({tag, ".busy"},  32'(busy_o),   32'h0);
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic exp_zero);
    start_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    tick();
    start_i   = 1'b0;
    chk({tag, ".data"},  data_o,         exp);
    chk({tag, ".zero"},  32'(zero_o),    32'(exp_zero));
    chk({tag, ".valid"}, 32'(valid_o),   32'h1);
    chk({tag, ".busy"},  32'(busy_o),    32'h0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_i     = 1'b1;
    start_i   = 1'b0;
    ALUCtrl_i = 4'h0;
    data1_i   = 32'h0;
    data2_i   = 32'h0;

    tick();
    chk_idle("reset");
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("idle");
    end

    issue("add",  4'b0011, 32'd5,        32'd7,    32'd12,        1'b0);
    issue("sub",  4'b0100, 32'd9,        32'd9,    32'd0,         1'b1);
    issue("beq",  4'b1001, 32'd3,        32'd4,    32'hFFFFFFFF,  1'b0);
    issue("sll",  4'b0010, 32'd1,        32'd31,   32'h80000000,  1'b0);
    issue("srai", 4'b0111, 32'h80000000, 32'd4,    32'hF8000000,  1'b0);
    issue("and",  4'b0000, 32'h0000F0F0, 32'hFF00, 32'h0000F000,  1'b0);
    issue("xor",  4'b0001, 32'h000000FF, 32'h0F,   32'h000000F0,  1'b0);
    issue("addi", 4'b0110, 32'hFFFFFFFF, 32'd2,    32'd1,         1'b0);
    issue("lwsw", 4'b1000, 32'h00001000, 32'h24,   32'h00001024,  1'b0);
    issue("op15", 4'b1111, 32'd5,        32'd7,    32'd0,         1'b1);
    tick();
    chk("single_pulse", 32'(valid_o), 32'h0);

    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_idle("mid_reset");

`ifdef ALU_FAST_MUL_EN
    issue("fmul",  4'b0101, 32'd6,        32'd7, 32'd42,        1'b0);
    issue("fmul2", 4'b0101, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD,  1'b0);
    tick();
    chk("fmul.busy", 32'(busy_o), 32'h0);
`else
    issue("pre_mul", 4'b0011, 32'd5, 32'd7, 32'd12, 1'b0);

    // mul accepted in cycle N; add 1+1 held on start_i from N+1 onward
    start_i   = 1'b1;
    ALUCtrl_i = 4'b0101;
    data1_i   = 32'hFFFFFFFF;
    data2_i   = 32'd3;
    tick();
    ALUCtrl_i = 4'b0011;
    data1_i   = 32'd1;
    data2_i   = 32'd1;
    for (int k = 1; k <= 32; k++) begin
      chk("mul.busy",  32'(busy_o),  32'h1);
      chk("mul.valid", 32'(valid_o), 32'h0);
      chk("mul.hold",  data_o,       32'd12);
      tick();
    end
    chk("mul.done_busy",  32'(busy_o),  32'h0);
    chk("mul.done_valid", 32'(valid_o), 32'h1);
    chk("mul.product",    data_o,       32'hFFFFFFFD);
    chk("mul.zero",       32'(zero_o),  32'h0);
    tick();
    start_i = 1'b0;
    chk("reissue.data",  data_o,        32'd2);
    chk("reissue.valid", 32'(valid_o),  32'h1);
    chk("reissue.busy",  32'(busy_o),   32'h0);
    tick();
    chk("reissue.pulse", 32'(valid_o),  32'h0);

    // mul 6x7 aborted by reset in cycle N+10
    start_i   = 1'b1;
    ALUCtrl_i = 4'b0101;
    data1_i   = 32'd6;
    data2_i   = 32'd7;
    tick();
    start_i = 1'b0;
    for (int k = 1; k < 10; k++) begin
      chk("abort.busy", 32'(busy_o), 32'h1);
      tick();
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_idle("abort.reset");
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("abort.no_valid", 32'(valid_o), 32'h0);
      chk("abort.no_busy",  32'(busy_o),  32'h0);
    end
    issue("post_abort", 4'b0011, 32'd1, 32'd1, 32'd2, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
